pipe_reg_controller: RTL

//   Sequences a chain of STAGES Intermediate_Register instances as an elastic pipeline.

---
 rtl/pipe_reg_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_reg_controller.sv
// Control plane for an elastic chain of STAGES enabled registers: per-stage valid
// tracking, register enables, valid/ready handshakes, hold, flush and drain sequencing.
`timescale 1ns/1ps

module pipe_reg_controller #(
    parameter int STAGES       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          hold,
    input  logic                          flush,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic [STAGES-1:0]             stage_en,
    output logic [STAGES-1:0]             stage_valid,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W  = $clog2(STAGES + 1);
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [STAGES-1:0]   valid_q, valid_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                drain_done_q, drain_done_d;

    logic [STAGES-1:0]   adv;
    logic                full_above;
    logic                move_ok;
    logic                accept;
    logic                xfer;

    // adv[i] is true when stage i may load: some stage at or beyond i is empty,
    // or the last stage is being consumed. Built without a bit-to-bit comb loop.
    always_comb begin
        adv        = '0;
        full_above = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_above = full_above & valid_q[i];
            adv[i]     = out_ready | ~full_above;
        end
    end

    assign move_ok  = rst & ~hold & ~flush & (state_q != ST_FLUSH);
    assign stage_en = move_ok ? adv : '0;
    assign in_ready = move_ok & (state_q == ST_RUN) & adv[0];
    assign accept   = in_valid & in_ready;
    assign xfer     = valid_q[STAGES-1] & out_ready & move_ok;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (stage_en[0]) begin
                valid_d[0] = accept;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (stage_en[i]) begin
                    valid_d[i] = valid_q[i-1];
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(xfer);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                end else if (drain_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                // A fresh flush while flushing restarts the quiet period.
                if (flush) begin
                    fcnt_d = '0;
                end else if (fcnt_q == FCNT_LAST) begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                end else if (!drain_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // Rises the cycle after the pipe is seen empty in DRAIN; drops with the exit edge.
    assign drain_done_d = (state_q == ST_DRAIN) & (state_d == ST_DRAIN) & (occ_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            fcnt_q       <= '0;
            valid_q      <= '0;
            occ_q        <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign occupancy   = occ_q;
    assign drain_done  = drain_done_q;

endmodule
